mg_div16u: RTL
==============

MG_DIV16U -- requirements
Module: mg_div16u

Interface
REQ-001 Parameter DW, default 16: dividend and quotient width.
REQ-002 Parameter VW, default 8: divisor and remainder width; DW >= VW SHALL hold.
REQ-003 clk  input  1  single clock; all state SHALL change on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  dividend/divisor operands valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 dividend  input  DW  unsigned dividend.
REQ-008 divisor  input  VW  unsigned divisor.
REQ-009 out_valid  output  1  quotient/remainder valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 quotient  output  DW  unsigned quotient, registered.
REQ-012 remainder  output  VW  unsigned remainder, registered.
REQ-013 dbz  output  1  divide-by-zero flag; present only when MG_DIV_DBZ_FAST_EN is defined.

Function
REQ-014 The block SHALL be an unsigned iterative restoring divider producing one quotient bit per cycle, MSB first.
REQ-015 State machine: IDLE, BUSY, DONE; reset state IDLE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 IDLE->BUSY on the edge where in_valid && in_ready; operands latched on that edge (E0), and the iteration counter loaded to DW.
REQ-018 Each BUSY edge: partial remainder (VW+1 bits) = {rem, next dividend bit}; if >= divisor, subtract and set quotient bit to 1, else keep and set it to 0; the counter decrements.
REQ-019 BUSY->DONE on the edge the last iteration completes (E_DW, i.e. E16 by default); out_valid SHALL be high in the cycle after E_DW.
REQ-020 DONE->IDLE on the edge where out_valid && out_ready; there is no overlap, so the next acceptance is possible no earlier than the following edge.
REQ-021 While out_valid && !out_ready, quotient, remainder and dbz SHALL hold stable, and in_ready SHALL stay 0.
REQ-022 in_valid while not in IDLE SHALL be ignored, and the operands SHALL not be sampled.
REQ-023 Result SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for every divisor != 0.
REQ-024 For divisor == 0 the result SHALL be quotient = all ones and remainder = dividend[VW-1:0], in both configurations.
REQ-025 The quotient and remainder registers SHALL update only on the BUSY->DONE transition.
REQ-026 The quotient and remainder registers SHALL not be cleared on leaving DONE.

Reset
REQ-027 On rst_n low, the block SHALL enter IDLE immediately and asynchronously, with in_ready=1 during reset, out_valid=0, quotient=0, remainder=0, dbz=0, and the counter and partial remainder at 0.
REQ-028 A reset asserted in BUSY or DONE SHALL discard the operation in progress.
REQ-029 No output SHALL be produced for a discarded operation after rst_n is released.

Configuration
REQ-030 The macro MG_DIV_DBZ_FAST_EN SHALL control divide-by-zero handling.
REQ-031 When MG_DIV_DBZ_FAST_EN is defined: the dbz port exists; an accepted divisor == 0 SHALL go IDLE->BUSY->DONE with exactly one BUSY cycle (out_valid after E1); the REQ-024 values SHALL be loaded and dbz=1 while in DONE; dbz=0 for every nonzero divisor.
REQ-032 When MG_DIV_DBZ_FAST_EN is not defined: there is no dbz port; divisor == 0 SHALL take the full DW iterations; the REQ-024 values SHALL fall out of the normal algorithm.

Verification
REQ-033 Basic division: dividend=1000, divisor=7, out_ready=1 -> quotient=142, remainder=6, out_valid first high the cycle after E16, in_ready low E0..DONE.
REQ-034 Extremes: 0xFFFF/0xFF -> 0x0101 rem 0; 5/200 -> 0 rem 5; 0/3 -> 0 rem 0.
REQ-035 Divide by zero: 0x1234/0 -> quotient 0xFFFF, remainder 0x34; with the macro, dbz=1 and out_valid after E1; without it, out_valid after E16.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles in DONE, toggling in_valid and operands -> outputs stable, in_ready=0; then release -> IDLE next cycle, and the next operands accepted.
REQ-037 Reset mid-operation: assert rst_n low after E8 of 1000/7 -> out_valid=0, quotient=0, in_ready=1 immediately; then a new 100/9 -> 11 rem 1.
REQ-038 Random sweep: 10k random operands including divisor 0, with random out_ready -> every result matches REQ-023/REQ-024.

Source files
------------

// File: rtl/mg_div16u.sv
// -----------------------------------------------------------------------------
// mg_div16u -- unsigned iterative restoring divider, one quotient bit per cycle.
//
// Optional feature macro: MG_DIV_DBZ_FAST_EN
//   defined   : dbz port exists. A zero divisor finishes after a single BUSY
//               cycle, and dbz is raised with the result.
//   undefined : no dbz port. A zero divisor runs the full DW iterations. The
//               all-ones quotient and dividend[VW-1:0] remainder come out of
//               the normal algorithm.
//
// Parameters
//   DW : dividend / quotient width (default 16)
//   VW : divisor / remainder width (default 8), DW >= VW
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands valid
//   in_ready   out  high only in IDLE
//   dividend   in   DW-bit unsigned dividend
//   divisor    in   VW-bit unsigned divisor
//   out_valid  out  high only in DONE
//   out_ready  in   consumer accepts the result
//   quotient   out  DW-bit registered quotient
//   remainder  out  VW-bit registered remainder
//   dbz        out  divide-by-zero flag (only with MG_DIV_DBZ_FAST_EN)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer keeps valid and data stable until that edge. in_valid is
// ignored, and the operands are not sampled, outside IDLE.
// -----------------------------------------------------------------------------
module mg_div16u #(
   parameter int DW = 16,
   parameter int VW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder
`ifdef MG_DIV_DBZ_FAST_EN
   ,
   output logic          dbz
`endif
);

   localparam int CW = $clog2(DW + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   // Holds the dividend. It shifts left each iteration, and quotient bits
   // enter at the LSB. After DW steps it holds the quotient.
   logic [DW-1:0] dq_q, dq_d;
   logic [VW-1:0] dvs_q, dvs_d;
   logic [VW-1:0] rem_q, rem_d;
   logic [DW-1:0] quo_q, quo_d;
   logic [VW-1:0] rmd_q, rmd_d;
`ifdef MG_DIV_DBZ_FAST_EN
   logic          dbz_q, dbz_d;
`endif

   // One restoring step. The running remainder is always below the divisor,
   // so the difference fits in VW bits. With divisor == 0 every step
   // "subtracts" zero and keeps the low VW bits. That is what gives
   // quotient = all ones and remainder = dividend[VW-1:0].
   logic [VW:0]   shifted;
   logic          ge;
   logic [VW-1:0] rem_step;
   logic [DW-1:0] dq_step;

   always_comb begin
      shifted  = {rem_q, dq_q[DW-1]};
      ge       = (shifted >= {1'b0, dvs_q});
      rem_step = ge ? (shifted[VW-1:0] - dvs_q) : shifted[VW-1:0];
      dq_step  = {dq_q[DW-2:0], ge};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dq_d    = dq_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
`ifdef MG_DIV_DBZ_FAST_EN
      dbz_d   = dbz_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = BUSY;
               dq_d    = dividend;
               dvs_d   = divisor;
               rem_d   = '0;
               cnt_d   = CW'(DW);
            end
         end
         BUSY: begin
`ifdef MG_DIV_DBZ_FAST_EN
            if (dvs_q == '0) begin
               state_d = DONE;
               cnt_d   = '0;
               quo_d   = '1;
               rmd_d   = dq_q[VW-1:0];
               dbz_d   = 1'b1;
            end else
`endif
            begin
               dq_d  = dq_step;
               rem_d = rem_step;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = DONE;
                  quo_d   = dq_step;
                  rmd_d   = rem_step;
`ifdef MG_DIV_DBZ_FAST_EN
                  dbz_d   = 1'b0;
`endif
               end
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dq_q    <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         rmd_q   <= '0;
`ifdef MG_DIV_DBZ_FAST_EN
         dbz_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dq_q    <= dq_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
`ifdef MG_DIV_DBZ_FAST_EN
         dbz_q   <= dbz_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign quotient  = quo_q;
   assign remainder = rmd_q;
`ifdef MG_DIV_DBZ_FAST_EN
   assign dbz       = dbz_q;
`endif

endmodule
